// File: rtl/adc_acq_window_gen.sv
// ---------------------------------------------------------------------------
// adc_acq_window_gen
// Generates the ADC acquisition enable inside each acquisition window of the
// NMR echo train. On every ACQ_WND rising edge the block waits ADC_INIT_DELAY
// clocks, then holds ACQ_EN high for exactly SAMPLES_PER_ECHO clocks. Delay
// and length are latched at the trigger edge. A window that drops early
// aborts the pulse.
//
// Ports:
//   CLK              in   system clock, rising edge
//   RESET            in   synchronous, active-high reset
//   ADC_INIT_DELAY   in   [DATABUS_WIDTH] clocks from window edge to ACQ_EN
//   SAMPLES_PER_ECHO in   [DATABUS_WIDTH] ACQ_EN high time in clocks
//   ACQ_WND          in   acquisition window level, rising edge triggers
//   ACQ_EN           out  registered acquisition enable
//
// Build option: define ADC_ACQ_WND_SYNC_EN to pass ACQ_WND through a 2-flop
// synchronizer (flops reset to 1) before edge detection. All trigger and
// abort timing then moves 2 cycles later.
// ---------------------------------------------------------------------------
module adc_acq_window_gen #(
   parameter int unsigned DATABUS_WIDTH = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [DATABUS_WIDTH-1:0] ADC_INIT_DELAY,
   input  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO,
   input  logic                     ACQ_WND,
   output logic                     ACQ_EN
);

   localparam int unsigned DW = DATABUS_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      ACQ   = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   dly_q, dly_d;
   logic [DW-1:0]   smp_q, smp_d;
   logic            wnd_q;
   logic            acq_en_q;
   logic            wnd_s;
   logic            trig;

   // Window source: optionally synchronized from a foreign domain
`ifdef ADC_ACQ_WND_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], ACQ_WND};
      end
   end

   assign wnd_s = sync_q[1];
`else
   assign wnd_s = ACQ_WND;
`endif

   // History resets high so a window already open at reset release is ignored
   assign trig = wnd_s & ~wnd_q;

   // State, counter, latched settings and output registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dly_q    <= '0;
         smp_q    <= '0;
         wnd_q    <= 1'b1;
         acq_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dly_q    <= dly_d;
         smp_q    <= smp_d;
         wnd_q    <= wnd_s;
         acq_en_q <= (state_d == ACQ);
      end
   end

   // Next-state logic; a low window in DELAY/ACQ aborts back to IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      smp_d   = smp_q;

      case (state_q)
         IDLE: begin
            if (trig) begin
               dly_d = ADC_INIT_DELAY;
               smp_d = SAMPLES_PER_ECHO;
               cnt_d = DW'(1);
               if (SAMPLES_PER_ECHO == '0) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else if (ADC_INIT_DELAY == '0) begin
                  state_d = ACQ;
               end else begin
                  state_d = DELAY;
               end
            end
         end

         DELAY: begin
            if (!wnd_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == dly_q) begin
               state_d = ACQ;
               cnt_d   = DW'(1);
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end

         ACQ: begin
            if (!wnd_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == smp_q) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end

         DONE: begin
            if (!wnd_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign ACQ_EN = acq_en_q;

endmodule

// File: tb/tb_adc_acq_window_gen.sv
// ---------------------------------------------------------------------------
// tb_adc_acq_window_gen
// Self-checking bench: directed scenarios followed by random windows. The
// expected ACQ_EN is derived from the trigger edge index and the latched
// delay/length with plain arithmetic, then compared every clock.
// ---------------------------------------------------------------------------
module tb_adc_acq_window_gen;

   logic        clk;
   logic        rst;
   logic [31:0] dly;
   logic [31:0] smp;
   logic        wnd;
   logic        acq_en;

   int unsigned checks;
   int unsigned passed;

   // Reference model state
   longint      edge_idx;
   longint      trig_edge;
   longint      lat_d;
   longint      lat_n;
   bit          alive;
   bit          prev_wnd;
   logic        exp_en;

   adc_acq_window_gen #(.DATABUS_WIDTH(32)) dut (
      .CLK              (clk),
      .RESET            (rst),
      .ADC_INIT_DELAY   (dly),
      .SAMPLES_PER_ECHO (smp),
      .ACQ_WND          (wnd),
      .ACQ_EN           (acq_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the model by one rising edge using the inputs sampled there
   task automatic model_edge();
      edge_idx++;
      if (rst) begin
         alive    = 1'b0;
         prev_wnd = 1'b1;
      end else begin
         if (wnd && !prev_wnd) begin
            trig_edge = edge_idx;
            lat_d     = longint'(dly);
            lat_n     = longint'(smp);
            alive     = 1'b1;
         end else if (!wnd) begin
            alive = 1'b0;
         end
         prev_wnd = wnd;
      end
      exp_en = alive && (edge_idx - trig_edge >= lat_d) &&
               (edge_idx - trig_edge < lat_d + lat_n);
   endtask

   // Run n clocks with the given inputs, checking ACQ_EN after every edge
   task automatic run(input int n, input logic r, input logic w,
                      input logic [31:0] d, input logic [31:0] s);
      for (int i = 0; i < n; i++) begin
         rst = r;
         wnd = w;
         dly = d;
         smp = s;
         @(posedge clk);
         model_edge();
         #1;
         checks++;
         assert (acq_en === exp_en) passed++;
         else $error("FAIL acq_en edge=%0d observed=%b expected=%b",
                     edge_idx, acq_en, exp_en);
      end
   endtask

   int unsigned hi_len;
   int unsigned lo_len;
   int unsigned cut;
   logic [31:0] rd;
   logic [31:0] rn;

   initial begin
      checks    = 0;
      passed    = 0;
      edge_idx  = 0;
      trig_edge = 0;
      lat_d     = 0;
      lat_n     = 0;
      alive     = 1'b0;
      prev_wnd  = 1'b1;
      exp_en    = 1'b0;
      rst = 1'b1; wnd = 1'b0; dly = 32'd0; smp = 32'd0;

      // Reset, then a long window and a repeat after a 10-cycle gap
      run(2,   1'b1, 1'b0, 32'd3, 32'd10);
      run(3,   1'b0, 1'b0, 32'd3, 32'd10);
      run(100, 1'b0, 1'b1, 32'd3, 32'd10);
      run(10,  1'b0, 1'b0, 32'd3, 32'd10);
      run(100, 1'b0, 1'b1, 32'd3, 32'd10);
      run(3,   1'b0, 1'b0, 32'd3, 32'd10);

      // Zero delay with single sample; zero samples never asserts
      run(5,   1'b0, 1'b1, 32'd0, 32'd1);
      run(3,   1'b0, 1'b0, 32'd0, 32'd1);
      run(15,  1'b0, 1'b1, 32'd5, 32'd0);
      run(3,   1'b0, 1'b0, 32'd5, 32'd0);

      // Window dropped during ACQ, then during DELAY
      run(6,   1'b0, 1'b1, 32'd3, 32'd10);
      run(5,   1'b0, 1'b0, 32'd3, 32'd10);
      run(2,   1'b0, 1'b1, 32'd3, 32'd10);
      run(5,   1'b0, 1'b0, 32'd3, 32'd10);

      // Settings changed mid-window only affect the next window
      run(1,   1'b0, 1'b1, 32'd2, 32'd4);
      run(19,  1'b0, 1'b1, 32'd4, 32'd6);
      run(3,   1'b0, 1'b0, 32'd4, 32'd6);
      run(20,  1'b0, 1'b1, 32'd4, 32'd6);
      run(3,   1'b0, 1'b0, 32'd4, 32'd6);

      // Window held across reset release gives no pulse
      run(2,   1'b0, 1'b1, 32'd1, 32'd3);
      run(2,   1'b1, 1'b1, 32'd1, 32'd3);
      run(10,  1'b0, 1'b1, 32'd1, 32'd3);
      run(2,   1'b0, 1'b0, 32'd1, 32'd3);

      // Reset during ACQ, then a fresh edge yields a normal pulse
      run(5,   1'b0, 1'b1, 32'd2, 32'd8);
      run(1,   1'b1, 1'b1, 32'd2, 32'd8);
      run(2,   1'b0, 1'b0, 32'd2, 32'd8);
      run(15,  1'b0, 1'b1, 32'd2, 32'd8);
      run(2,   1'b0, 1'b0, 32'd2, 32'd8);

      // Large delay with the top bit set: must wait, not wrap
      run(20,  1'b0, 1'b1, 32'hFFFF_FFF0, 32'd5);
      run(2,   1'b0, 1'b0, 32'd0, 32'd0);

      // Random windows, settings and occasional resets
      for (int t = 0; t < 60; t++) begin
         hi_len = $urandom_range(20, 1);
         lo_len = $urandom_range(5, 1);
         rd     = 32'($urandom_range(6, 0));
         rn     = 32'($urandom_range(8, 0));
         if ($urandom_range(4, 0) == 0) begin
            cut = $urandom_range(hi_len, 1);
            run(int'(cut), 1'b0, 1'b1, rd, rn);
            run(int'(hi_len), 1'b0, 1'b1, 32'($urandom_range(6, 0)),
                32'($urandom_range(8, 0)));
         end else begin
            run(int'(hi_len), 1'b0, 1'b1, rd, rn);
         end
         if ($urandom_range(9, 0) == 0) begin
            run(1, 1'b1, 1'($urandom_range(1, 0)), rd, rn);
         end
         run(int'(lo_len), 1'b0, 1'b0, rd, rn);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
